m68k_sdram_controller: RTL and testbench
========================================

M68K_SDRAM_CONTROLLER -- requirements
Module: m68k_sdram_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INIT_DELAY, 5000: power-up wait in clocks (100 us at 50 MHz).
- REFRESH_INTERVAL, 375: clocks between auto-refreshes.
- TRFC, 7: clocks after an AUTO REFRESH command.
- TRP, 2: clocks after a precharge.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clock, in, 1: single clock; all state changes on its rising edge.
- Reset_L, in, 1: asynchronous active-low reset.
- DramSelect_L, in, 1: access request from the cache controller.
- AS_L, in, 1: address strobe.
- WE_L, in, 1: write (low) or read (high).
- UDS_L, in, 1: upper byte strobe.
- LDS_L, in, 1: lower byte strobe.
- Address, in, 32: byte address.
- DataIn, in, 16: write data.
- DataOut, out, 16: registered read data.
- Dtack_L, out, 1: transfer acknowledge.
- SDram_CKE_H, SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L, out, 1 each: SDRAM command pins.
- SDram_Addr, out, 13: SDRAM address bus.
- SDram_BA, out, 2: SDRAM bank select.
- SDram_DQM, out, 2: byte masks, [1] = upper byte.
- SDram_DQ_Out, out, 16: SDRAM write data.
- SDram_DQ_OE_H, out, 1: DQ output enable.
- SDram_DQ_In, in, 16: SDRAM read data.
- ControllerState, out, 5: current state, for debug.

Function
REQ-003 Address mapping SHALL be: bank = Address[25:24], row = Address[23:11], column = Address[10:1].
REQ-004 All SDRAM command pins SHALL be registered.
REQ-005 Power-up sequence SHALL be: CKE high with NOP for INIT_DELAY clocks; PRECHARGE ALL (A10=1); TRP NOPs; two rounds of AUTO REFRESH followed by TRFC NOPs; LOAD MODE with SDram_Addr=13'h223 (burst 8, sequential, CAS latency 2, single-location writes); 2 NOPs; then Idle.
REQ-006 Idle SHALL issue NOP.
- A pending refresh has priority: it issues AUTO REFRESH, waits TRFC clocks, and returns to Idle.
- Otherwise, DramSelect_L=0 and AS_L=0 issues ACTIVE, then one NOP (tRCD).
REQ-007 A read SHALL issue READ with auto-precharge (A10=1) and DQM=00.
- Then 2 CAS-latency clocks.
- Then 8 clocks with DataOut <= SDram_DQ_In each clock.
REQ-008 A write SHALL issue WRITE with auto-precharge, DQM={UDS_L,LDS_L}, SDram_DQ_OE_H=1 for that cycle only, and SDram_DQ_Out=DataIn.
REQ-009 Dtack_L SHALL be driven low:
- for a write, from the clock after the WRITE command;
- for a read, from the clock after the 8th burst word.
- In both cases it stays low until AS_L=1 or DramSelect_L=1.
REQ-010 After an access completes, the block SHALL wait TRP clocks before re-entering Idle.
- It never re-enters Idle while AS_L=0 for the same cycle.
REQ-011 The refresh counter SHALL count down from REFRESH_INTERVAL-1 and set refresh-pending at 0, then reload.
- Pending is cleared when AUTO REFRESH issues.
- An expiry during an access stays pending until the next Idle.
REQ-012 A refresh and a new request in the same Idle clock SHALL resolve refresh first.
- The request is served afterwards; AS_L is held throughout.
REQ-013 During a refresh command the block SHALL drive SDram_CAS_L=0 and SDram_RAS_L=0, so downstream logic can tell a refresh from a read (CAS_L=0, RAS_L=1).
REQ-014 The counter wrap from 0 to reload SHALL not lose a pending request.
- Two expiries before service collapse into one refresh.

Reset
REQ-015 Reset_L=0 SHALL asynchronously force:
- the init state;
- CKE=0, CS_L=1, RAS_L=1, CAS_L=1, WE_L=1;
- Dtack_L=1, DQ_OE_H=0, DQM=11;
- DataOut=0, SDram_Addr=0, BA=0;
- refresh pending cleared and counters reset.
REQ-016 Reset asserted mid-burst or mid-write SHALL abort immediately, and the full power-up sequence SHALL rerun.

Configuration
REQ-017 With SDRAM_REFRESH_EN defined, periodic refresh SHALL operate per REQ-011.
REQ-018 Without SDRAM_REFRESH_EN, the refresh counter SHALL not exist and no periodic refresh SHALL occur; only the two init refreshes issue. This build is for simulation only.

Structure
REQ-019 Package m68k_sdram_pkg SHALL hold:
- command encodings {CS,RAS,CAS,WE}: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001, LOAD MODE 0000;
- the state encodings;
- the mode constant 13'h223.
REQ-020 Sub-module sdram_refresh_timer SHALL hold the refresh counter and the pending flag, with inputs refresh_ack and outputs refresh_req.

Verification
REQ-021 Reset release -> NOP for INIT_DELAY clocks, then PRE, 2x REF, MRS 13'h223, Idle.
REQ-022 Read at Address 32'h0000_1230 -> ACTIVE row 2, bank 0; READ col 24'h118 with A10=1; words 0..7 on DataOut in clocks 3..10 after READ; Dtack_L low after the 8th word.
REQ-023 Byte write with UDS_L=1, LDS_L=0, DataIn=16'hA55A -> WRITE with DQM=10 and DQ_Out=A55A; Dtack_L low the next clock and high after AS_L=1.
REQ-024 Refresh expiry mid-burst -> burst completes, then REF issues at the next Idle before a queued request.
REQ-025 Reset_L pulsed low during burst word 4 -> outputs at reset values that same clock; init sequence restarts.

Source files
------------

// File: rtl/m68k_sdram_pkg.sv
// Shared SDRAM command encodings, controller state encodings and mode-register value.
// Periodic refresh is enabled by defining SDRAM_REFRESH_EN (see sdram_refresh_timer).
package m68k_sdram_pkg;

  // Command bits are ordered {CS_L, RAS_L, CAS_L, WE_L}.
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111,
    CMD_INHIBIT   = 4'b1111
  } sdram_cmd_e;

  typedef enum logic [4:0] {
    S_INIT_WAIT = 5'd0,
    S_INIT_TRP  = 5'd1,
    S_INIT_RFC1 = 5'd2,
    S_INIT_RFC2 = 5'd3,
    S_INIT_MRD  = 5'd4,
    S_IDLE      = 5'd5,
    S_REF_WAIT  = 5'd6,
    S_RCD       = 5'd7,
    S_RW        = 5'd8,
    S_CAS       = 5'd9,
    S_BURST     = 5'd10,
    S_ACK       = 5'd11,
    S_HOLD      = 5'd12,
    S_PRE_WAIT  = 5'd13
  } ctrl_state_e;

  // Burst length 8, sequential, CAS latency 2, single-location writes.
  localparam logic [12:0] MODE_REG    = 13'h223;
  localparam int          CAS_LATENCY = 2;
  localparam int          BURST_LEN   = 8;

  // Column address with A10 set so every access auto-precharges.
  function automatic logic [12:0] col_addr(input logic [31:0] addr);
    return {2'b00, 1'b1, addr[10:1]};
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh interval counter with a sticky pending flag.
// Only present when SDRAM_REFRESH_EN is defined; otherwise refresh_req is tied low.
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 375
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic refresh_ack,
  output logic refresh_req
);

`ifdef SDRAM_REFRESH_EN
  localparam int CW = $clog2(REFRESH_INTERVAL + 1);

  logic [CW-1:0] count;
  logic          pending;
  logic          expire;

  assign expire = run && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= CW'(REFRESH_INTERVAL - 1);
      pending <= 1'b0;
    end else begin
      if (run) begin
        if (count == '0) count <= CW'(REFRESH_INTERVAL - 1);
        else             count <= count - CW'(1);
      end
      // A fresh expiry wins over an ack in the same clock, and repeated
      // expiries before service merge into a single pending refresh.
      pending <= (pending & ~refresh_ack) | expire;
    end
  end

  assign refresh_req = pending;
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst_n, run, refresh_ack};
  assign refresh_req   = 1'b0;
`endif

endmodule

// File: rtl/m68k_sdram_controller.sv
// 68000-bus SDRAM controller: power-up init, single-burst reads, masked writes, auto-refresh.
// Periodic refresh is compiled in only with SDRAM_REFRESH_EN defined.
import m68k_sdram_pkg::*;

module m68k_sdram_controller #(
  parameter int INIT_DELAY       = 5000,
  parameter int REFRESH_INTERVAL = 375,
  parameter int TRFC             = 7,
  parameter int TRP              = 2
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        DramSelect_L,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic [31:0] Address,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Dtack_L,
  output logic        SDram_CKE_H,
  output logic        SDram_CS_L,
  output logic        SDram_RAS_L,
  output logic        SDram_CAS_L,
  output logic        SDram_WE_L,
  output logic [12:0] SDram_Addr,
  output logic [1:0]  SDram_BA,
  output logic [1:0]  SDram_DQM,
  output logic [15:0] SDram_DQ_Out,
  output logic        SDram_DQ_OE_H,
  input  logic [15:0] SDram_DQ_In,
  output logic [4:0]  ControllerState
);

  ctrl_state_e state;
  sdram_cmd_e  cmd;
  logic [15:0] cnt;
  logic        init_done;
  logic        refresh_req;
  logic        refresh_ack;
  logic        unused_addr;

  assign {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = cmd;
  assign ControllerState = state;
  assign refresh_ack     = (state == S_IDLE) && refresh_req;
  assign unused_addr     = &{1'b0, Address[31:26], Address[0]};

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk        (Clock),
    .rst_n      (Reset_L),
    .run        (init_done),
    .refresh_ack(refresh_ack),
    .refresh_req(refresh_req)
  );

  // Wait states load the count so the next command follows exactly N NOPs.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state         <= S_INIT_WAIT;
      cnt           <= 16'(INIT_DELAY);
      cmd           <= CMD_INHIBIT;
      SDram_CKE_H   <= 1'b0;
      SDram_Addr    <= '0;
      SDram_BA      <= '0;
      SDram_DQM     <= 2'b11;
      SDram_DQ_Out  <= '0;
      SDram_DQ_OE_H <= 1'b0;
      DataOut       <= '0;
      Dtack_L       <= 1'b1;
      init_done     <= 1'b0;
    end else begin
      cmd           <= CMD_NOP;
      SDram_DQ_OE_H <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          SDram_CKE_H <= 1'b1;
          if (cnt == 16'd0) begin
            cmd        <= CMD_PRECHARGE;
            SDram_Addr <= 13'h0400;
            cnt        <= 16'(TRP);
            state      <= S_INIT_TRP;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_TRP: begin
          if (cnt == 16'd0) begin
            cmd   <= CMD_REFRESH;
            cnt   <= 16'(TRFC);
            state <= S_INIT_RFC1;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_RFC1: begin
          if (cnt == 16'd0) begin
            cmd   <= CMD_REFRESH;
            cnt   <= 16'(TRFC);
            state <= S_INIT_RFC2;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_RFC2: begin
          if (cnt == 16'd0) begin
            cmd        <= CMD_LOAD_MODE;
            SDram_Addr <= MODE_REG;
            SDram_BA   <= 2'b00;
            cnt        <= 16'd1;
            state      <= S_INIT_MRD;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_MRD: begin
          if (cnt == 16'd0) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else cnt <= cnt - 16'd1;
        end
        S_IDLE: begin
          if (refresh_req) begin
            cmd   <= CMD_REFRESH;
            cnt   <= 16'(TRFC - 1);
            state <= S_REF_WAIT;
          end else if (!DramSelect_L && !AS_L) begin
            cmd        <= CMD_ACTIVE;
            SDram_BA   <= Address[25:24];
            SDram_Addr <= Address[23:11];
            state      <= S_RCD;
          end
        end
        S_REF_WAIT: begin
          if (cnt == 16'd0) state <= S_IDLE;
          else              cnt   <= cnt - 16'd1;
        end
        S_RCD: state <= S_RW;
        S_RW: begin
          SDram_Addr <= col_addr(Address);
          if (!WE_L) begin
            cmd           <= CMD_WRITE;
            SDram_DQM     <= {UDS_L, LDS_L};
            SDram_DQ_Out  <= DataIn;
            SDram_DQ_OE_H <= 1'b1;
            state         <= S_ACK;
          end else begin
            cmd       <= CMD_READ;
            SDram_DQM <= 2'b00;
            cnt       <= 16'(CAS_LATENCY - 1);
            state     <= S_CAS;
          end
        end
        S_CAS: begin
          if (cnt == 16'd0) begin
            cnt   <= 16'(BURST_LEN - 1);
            state <= S_BURST;
          end else cnt <= cnt - 16'd1;
        end
        S_BURST: begin
          DataOut <= SDram_DQ_In;
          if (cnt == 16'd0) state <= S_ACK;
          else              cnt   <= cnt - 16'd1;
        end
        S_ACK: begin
          Dtack_L   <= 1'b0;
          SDram_DQM <= 2'b11;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          // Dtack drops on either strobe, but Idle waits for AS_L to end the bus cycle.
          if (AS_L || DramSelect_L) Dtack_L <= 1'b1;
          if (AS_L) begin
            cnt   <= 16'(TRP - 1);
            state <= S_PRE_WAIT;
          end
        end
        S_PRE_WAIT: begin
          if (cnt == 16'd0) state <= S_IDLE;
          else              cnt   <= cnt - 16'd1;
        end
        default: state <= S_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_sdram_controller.sv
// Self-checking bench for m68k_sdram_controller: init sequence, reads, byte writes,
// refresh ordering (SDRAM_REFRESH_EN builds) and asynchronous reset mid-burst.
import m68k_sdram_pkg::*;

module tb_m68k_sdram_controller;

  localparam int INIT_DELAY = 30;
  localparam int TRFC       = 7;
  localparam int TRP        = 2;
`ifdef SDRAM_REFRESH_EN
  localparam int REFRESH_INTERVAL = 10;
  localparam bit REF_EN           = 1'b1;
`else
  localparam int REFRESH_INTERVAL = 375;
  localparam bit REF_EN           = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b0;
  logic        DramSelect_L = 1'b1;
  logic        AS_L = 1'b1;
  logic        WE_L = 1'b1;
  logic        UDS_L = 1'b1;
  logic        LDS_L = 1'b1;
  logic [31:0] Address = '0;
  logic [15:0] DataIn = '0;
  logic [15:0] SDram_DQ_In = '0;
  logic [15:0] DataOut;
  logic        Dtack_L;
  logic        SDram_CKE_H, SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L;
  logic [12:0] SDram_Addr;
  logic [1:0]  SDram_BA;
  logic [1:0]  SDram_DQM;
  logic [15:0] SDram_DQ_Out;
  logic        SDram_DQ_OE_H;
  logic [4:0]  ControllerState;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] exp_q[$];

  m68k_sdram_controller #(
    .INIT_DELAY      (INIT_DELAY),
    .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .TRFC            (TRFC),
    .TRP             (TRP)
  ) dut (
    .Clock          (Clock),
    .Reset_L        (Reset_L),
    .DramSelect_L   (DramSelect_L),
    .AS_L           (AS_L),
    .WE_L           (WE_L),
    .UDS_L          (UDS_L),
    .LDS_L          (LDS_L),
    .Address        (Address),
    .DataIn         (DataIn),
    .DataOut        (DataOut),
    .Dtack_L        (Dtack_L),
    .SDram_CKE_H    (SDram_CKE_H),
    .SDram_CS_L     (SDram_CS_L),
    .SDram_RAS_L    (SDram_RAS_L),
    .SDram_CAS_L    (SDram_CAS_L),
    .SDram_WE_L     (SDram_WE_L),
    .SDram_Addr     (SDram_Addr),
    .SDram_BA       (SDram_BA),
    .SDram_DQM      (SDram_DQM),
    .SDram_DQ_Out   (SDram_DQ_Out),
    .SDram_DQ_OE_H  (SDram_DQ_OE_H),
    .SDram_DQ_In    (SDram_DQ_In),
    .ControllerState(ControllerState)
  );

  // Clock and watchdog
  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] cmd_now();
    return {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cke"},   SDram_CKE_H, 0);
    check({tag, "_cmd"},   cmd_now(), 4'hF);
    check({tag, "_dtack"}, Dtack_L, 1);
    check({tag, "_oe"},    SDram_DQ_OE_H, 0);
    check({tag, "_dqm"},   SDram_DQM, 2'b11);
    check({tag, "_dout"},  DataOut, 0);
    check({tag, "_addr"},  SDram_Addr, 0);
    check({tag, "_ba"},    SDram_BA, 0);
    check({tag, "_state"}, ControllerState, S_INIT_WAIT);
  endtask

  // Steps clocks until a non-NOP command appears; n = NOP cycles seen.
  task automatic count_nops(output int n, output logic [3:0] c);
    bit found;
    n = 0;
    c = CMD_NOP;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge Clock);
      c = cmd_now();
      if (c == CMD_NOP) n++;
      else found = 1'b1;
    end
    check("cmd_wait_bound", found, 1);
  endtask

  task automatic check_init();
    int n;
    logic [3:0] c;
    count_nops(n, c);
    check("init_nops", n, INIT_DELAY);
    check("init_cke", SDram_CKE_H, 1);
    check("init_pre", c, CMD_PRECHARGE);
    check("init_pre_a10", SDram_Addr[10], 1);
    count_nops(n, c);
    check("init_trp", n, TRP);
    check("init_ref1", c, CMD_REFRESH);
    count_nops(n, c);
    check("init_trfc1", n, TRFC);
    check("init_ref2", c, CMD_REFRESH);
    count_nops(n, c);
    check("init_trfc2", n, TRFC);
    check("init_mrs", c, CMD_LOAD_MODE);
    check("init_mode", SDram_Addr, 13'h223);
    repeat (2) @(negedge Clock);
    check("init_idle", ControllerState, S_IDLE);
  endtask

  // Waits for ACTIVE, optionally requiring a refresh to be served first.
  task automatic wait_active(input logic [31:0] addr, input bit expect_ref);
    int n;
    logic [3:0] c;
    count_nops(n, c);
    if (expect_ref) begin
      check("ref_first", c, CMD_REFRESH);
      count_nops(n, c);
      check("ref_trfc", n, TRFC);
    end else if (REF_EN) begin
      while (c == CMD_REFRESH) count_nops(n, c);
    end
    check("act_cmd", c, CMD_ACTIVE);
    check("act_bank", SDram_BA, addr[25:24]);
    check("act_row", SDram_Addr, addr[23:11]);
    @(negedge Clock);
    check("rcd_nop", cmd_now(), CMD_NOP);
    @(negedge Clock);
  endtask

  task automatic do_read(input logic [31:0] addr, input bit expect_ref, input int abort_word);
    logic [15:0] base;
    logic [17:0] e;
    int stray;
    base = 16'($urandom);
    Address = addr; WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, base + 16'(k)});
    wait_active(addr, expect_ref);
    check("rd_cmd", cmd_now(), CMD_READ);
    check("rd_col", SDram_Addr, {2'b00, 1'b1, addr[10:1]});
    check("rd_dqm", SDram_DQM, 2'b00);
    stray = 0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge Clock);
      if (cmd_now() != CMD_NOP) stray++;
      if (j >= 3 && j <= 10) begin
        e = exp_q.pop_front();
        check("rd_word", DataOut, e);
        if (j - 3 == abort_word) begin
          #2 Reset_L = 1'b0;
          #1 check_reset_values("abort");
          exp_q.delete();
          AS_L = 1'b1; DramSelect_L = 1'b1;
          return;
        end
      end
      if (j == 10) check("rd_dtack_early", Dtack_L, 1);
      if (j >= 2 && j <= 9) SDram_DQ_In = base + 16'(j - 2);
      else SDram_DQ_In = ~base;
    end
    check("rd_dtack", Dtack_L, 0);
    check("rd_burst_quiet", stray, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1;
    @(negedge Clock);
    check("rd_dtack_release", Dtack_L, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic uds, input logic lds,
                          input logic [15:0] data);
    logic [17:0] e;
    Address = addr; DataIn = data; WE_L = 1'b0; UDS_L = uds; LDS_L = lds;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    exp_q.push_back({uds, lds, data});
    wait_active(addr, 1'b0);
    e = exp_q.pop_front();
    check("wr_cmd", cmd_now(), CMD_WRITE);
    check("wr_col", SDram_Addr, {2'b00, 1'b1, addr[10:1]});
    check("wr_dqm", SDram_DQM, e[17:16]);
    check("wr_data", SDram_DQ_Out, e[15:0]);
    check("wr_oe", SDram_DQ_OE_H, 1);
    check("wr_dtack_early", Dtack_L, 1);
    @(negedge Clock);
    check("wr_oe_off", SDram_DQ_OE_H, 0);
    check("wr_dtack", Dtack_L, 0);
    repeat (3) @(negedge Clock);
    check("wr_dtack_hold", Dtack_L, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1; WE_L = 1'b1;
    @(negedge Clock);
    check("wr_dtack_release", Dtack_L, 1);
  endtask

  // Stimulus sequence and final report
  initial begin
    repeat (3) @(negedge Clock);
    check_reset_values("por");
    Reset_L = 1'b1;
    check_init();

    // With refresh built in, the first expiry lands mid-burst of this read.
    do_read(32'h0000_1230, 1'b0, -1);
    do_read(32'h0012_3456, REF_EN, -1);
    do_write(32'h0000_2000, 1'b1, 1'b0, 16'hA55A);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, 1'b0, -1);
      else
        do_write($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    repeat (60) @(negedge Clock);
    do_read(32'h03FF_FFFE, 1'b0, -1);

    do_read(32'h0100_0802, 1'b0, 4);
    repeat (2) @(negedge Clock);
    Reset_L = 1'b1;
    check_init();
    do_write(32'h0000_0010, 1'b0, 1'b1, 16'h1234);
    do_read(32'h0000_0010, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
